// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - state type and width helpers for the reset sequencer
package reset_pkg;

  typedef enum logic [2:0] {HOLD, WAIT_ACK, GAP, DONE, FAULT} rst_seq_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rtl/rst_seq_timer.sv - loadable down-counter that saturates at zero
module rst_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (load_i) begin
      r_count <= value_i;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired_o = (r_count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases downstream reset domains in order, gated on per-stage acks
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int   NUM_STAGES      = 4,
  parameter int   STRETCH         = 8,
  parameter int   STAGE_DELAY     = 16,
  parameter int   TIMEOUT         = 255,
  parameter logic OUTPUT_POLARITY = 1'b1,
  localparam int  IDX_W           = clog2_min1(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  sync_reset_i,
  input  logic                  soft_reset_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_reset_o,
  output logic                  all_ready_o,
  output logic                  fault_o,
  output logic [IDX_W-1:0]      fault_stage_o
);

  localparam int TMR_W = $clog2(max3(STRETCH, STAGE_DELAY, TIMEOUT) + 1);
  localparam logic [NUM_STAGES-1:0] ALL_ACTIVE = {NUM_STAGES{OUTPUT_POLARITY}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [IDX_W-1:0]      r_fault_stage, w_fault_stage_nxt;
  logic [IDX_W-1:0]      w_drop_idx;
  logic [NUM_STAGES-1:0] r_stage_reset;
  logic [NUM_STAGES-1:0] w_acked, w_dropped;
  logic                  r_all_ready, r_fault;
  logic                  w_any_drop, w_release;
  logic                  w_tmr_load, w_tmr_expired;
  logic [TMR_W-1:0]      w_tmr_value;

  rst_seq_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .load_i    (w_tmr_load),
    .value_i   (w_tmr_value),
    .expired_o (w_tmr_expired)
  );

  // Stage idx counts as acked once we have left WAIT_ACK for it (GAP or DONE).
  always_comb begin
    w_acked = '0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (r_state == WAIT_ACK || r_state == GAP || r_state == DONE) begin
        if (j < int'(r_idx)) begin
          w_acked[j] = 1'b1;
        end else if (j == int'(r_idx) && r_state != WAIT_ACK) begin
          w_acked[j] = 1'b1;
        end
      end
    end
  end

  assign w_dropped  = w_acked & ~stage_ack_i;
  assign w_any_drop = |w_dropped;

  always_comb begin
    w_drop_idx = '0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (w_dropped[j]) begin
        w_drop_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_fault_stage_nxt = r_fault_stage;
    w_release         = 1'b0;
    w_tmr_load        = 1'b0;
    w_tmr_value       = '0;
    if (sync_reset_i || soft_reset_i) begin
      w_state_nxt       = HOLD;
      w_idx_nxt         = '0;
      w_fault_stage_nxt = '0;
      w_tmr_load        = 1'b1;
      w_tmr_value       = TMR_W'(STRETCH);
    end else begin
      case (r_state)
        HOLD: begin
          if (w_tmr_expired) begin
            w_state_nxt = WAIT_ACK;
            w_idx_nxt   = '0;
            w_release   = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = TMR_W'(TIMEOUT - 1);
          end
        end
        WAIT_ACK: begin
          // A dropped ack outranks both a fresh ack and a timeout on the same edge.
          if (w_any_drop) begin
            w_state_nxt       = FAULT;
            w_fault_stage_nxt = w_drop_idx;
          end else if (stage_ack_i[r_idx]) begin
            w_state_nxt = (r_idx == LAST_IDX) ? DONE : GAP;
            w_tmr_load  = 1'b1;
            w_tmr_value = TMR_W'(STAGE_DELAY);
          end else if (w_tmr_expired) begin
            w_state_nxt       = FAULT;
            w_fault_stage_nxt = r_idx;
          end
        end
        GAP: begin
          if (w_any_drop) begin
            w_state_nxt       = FAULT;
            w_fault_stage_nxt = w_drop_idx;
          end else if (w_tmr_expired) begin
            w_state_nxt = WAIT_ACK;
            w_idx_nxt   = r_idx + 1'b1;
            w_release   = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = TMR_W'(TIMEOUT - 1);
          end
        end
        DONE: begin
          if (w_any_drop) begin
            w_state_nxt       = FAULT;
            w_fault_stage_nxt = w_drop_idx;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset_i) begin
      r_state       <= HOLD;
      r_idx         <= '0;
      r_fault_stage <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_fault_stage <= w_fault_stage_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset_i) begin
      r_stage_reset <= ALL_ACTIVE;
      r_all_ready   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_all_ready <= (w_state_nxt == DONE);
      r_fault     <= (w_state_nxt == FAULT);
      if (w_state_nxt == HOLD || w_state_nxt == FAULT) begin
        r_stage_reset <= ALL_ACTIVE;
      end else if (w_release) begin
        r_stage_reset[w_idx_nxt] <= ~OUTPUT_POLARITY;
      end
    end
  end

  assign stage_reset_o = r_stage_reset;
  assign all_ready_o   = r_all_ready;
  assign fault_o       = r_fault;
  assign fault_stage_o = r_fault_stage;

endmodule
